// File: rtl/mult18_serial.sv
// Sequential unsigned shift-add multiplier: one partial product per clock.
// Responds to a level-based calc_start/done four-phase handshake.
module mult18_serial #(
    parameter int WIDTH = 18
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    input  logic                 calc_start,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;

    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_sum;

    // Multiplicand shifted into the column selected by the current multiplier bit.
    assign partial = {{WIDTH{1'b0}}, a_q} << count_q;
    assign acc_sum = acc_q + (b_q[count_q] ? partial : '0);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = done_q;

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (calc_start) begin
                    a_d     = dataa;
                    b_d     = datab;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A dropped request wins over completion; result is left untouched.
                if (!calc_start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d   = acc_sum;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) begin
                        result_d = acc_sum;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (!calc_start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = (state_q == BUSY);

endmodule

// File: tb/tb_mult18_serial.sv
// Self-checking bench for mult18_serial: vector table, handshake corner cases
// and random operands against a plain-arithmetic product model.
module tb_mult18_serial;

    localparam int W       = 18;
    localparam int LATENCY = W + 1;   // edges from first sampled request to done

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [W-1:0]    dataa = '0;
    logic [W-1:0]    datab = '0;
    logic            calc_start = 1'b0;
    logic [2*W-1:0]  result;
    logic            done;
    logic            busy;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] last_prod = '0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs [6];

    mult18_serial #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .dataa      (dataa),
        .datab      (datab),
        .calc_start (calc_start),
        .result     (result),
        .done       (done),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full handshake: raise request, scramble operands while busy, expect the
    // product after LATENCY edges, optionally hold the request, then release.
    task automatic run_mult(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp, input int hold_cycles);
        int   n;
        logic busy_ok;
        dataa      = a;
        datab      = b;
        calc_start = 1'b1;
        busy_ok    = 1'b1;
        n          = 0;
        while (n < 40) begin
            tick();
            n++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            dataa = W'($urandom);
            datab = W'($urandom);
        end
        check({name, " latency"}, 64'(n), 64'(LATENCY));
        check({name, " result"}, 64'(result), 64'(exp));
        check({name, " busy during run"}, 64'(busy_ok), 64'(1));
        check({name, " busy at done"}, 64'(busy), 64'(0));
        if (done === 1'b1) last_prod = exp;
        for (int i = 0; i < hold_cycles; i++) begin
            dataa = W'($urandom);
            datab = W'($urandom);
            tick();
            check({name, " hold done"}, 64'(done), 64'(1));
            check({name, " hold result"}, 64'(result), 64'(exp));
        end
        calc_start = 1'b0;
        tick();
        check({name, " release done"}, 64'(done), 64'(0));
        check({name, " release result"}, 64'(result), 64'(last_prod));
    endtask

    initial begin
        logic seen_done;
        logic [W-1:0] ra, rb;

        vecs[0] = '{a: 18'h08240, b: 18'h07DC0, p: 36'h03FFAF000};
        vecs[1] = '{a: 18'h3FFFF, b: 18'h3FFFF, p: 36'hFFFF80001};
        vecs[2] = '{a: 18'h00000, b: 18'h12345, p: 36'h000000000};
        vecs[3] = '{a: 18'h3FFFF, b: 18'h00001, p: 36'h00003FFFF};
        vecs[4] = '{a: 18'h00001, b: 18'h20000, p: 36'h000020000};
        vecs[5] = '{a: 18'h20000, b: 18'h20000, p: 36'h400000000};

        // Asynchronous reset before any clock edge.
        #2 RST = 1'b0;
        #1;
        check("reset result", 64'(result), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        @(negedge CLK) RST = 1'b1;
        repeat (5) tick();
        check("idle result", 64'(result), 64'(0));
        check("idle done", 64'(done), 64'(0));
        check("idle busy", 64'(busy), 64'(0));

        run_mult("3x5", 18'd3, 18'd5, 36'd15, 0);

        // Abort after five busy edges: no done, previous product kept.
        dataa      = 18'd7;
        datab      = 18'd9;
        calc_start = 1'b1;
        tick();
        repeat (5) tick();
        check("abort busy before drop", 64'(busy), 64'(1));
        calc_start = 1'b0;
        tick();
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        check("abort result", 64'(result), 64'(last_prod));
        seen_done = 1'b0;
        repeat (25) begin
            tick();
            if (done !== 1'b0) seen_done = 1'b1;
        end
        check("abort no done", 64'(seen_done), 64'(0));
        check("abort result kept", 64'(result), 64'(36'd15));

        for (int i = 0; i < 6; i++)
            run_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, 0);

        // Hold the request past done while operands toggle, then a fresh request.
        run_mult("hold", 18'h01234, 18'h05678, model(18'h01234, 18'h05678), 10);
        run_mult("after hold", 18'h2ABCD, 18'h1F00F, model(18'h2ABCD, 18'h1F00F), 0);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_mult($sformatf("rand%0d", i), ra, rb, model(ra, rb), i % 3);
        end

        // Reset in the middle of a computation.
        dataa      = 18'h2AAAA;
        datab      = 18'h15555;
        calc_start = 1'b1;
        tick();
        repeat (9) tick();
        #2 RST = 1'b0;
        #1;
        check("midrun reset result", 64'(result), 64'(0));
        check("midrun reset done", 64'(done), 64'(0));
        check("midrun reset busy", 64'(busy), 64'(0));
        calc_start = 1'b0;
        last_prod  = '0;
        @(negedge CLK) RST = 1'b1;
        tick();
        run_mult("2x2 after reset", 18'd2, 18'd2, 36'd4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult18_serial.md
Name: mult18_serial

Overview:
- Sequential unsigned shift-add multiplier. It is the responder side of the level-based calc_start/done four-phase handshake that logistic_func_tiny-style initiators drive.
- Each of the two logistic multiply steps, x*(1-x) and mu*term, is issued to this block.
- Trades area for latency: one partial product per clock, no hard multiplier inferred.

Parameters:
WIDTH, 18, operand width in bits; result width is 2*WIDTH.

Ports:
CLK  input  1  calculation clock (CLK_calc domain of the caller)
RST  input  1  reset, asynchronous, active-low
dataa  input  WIDTH  multiplicand, unsigned
datab  input  WIDTH  multiplier, unsigned
calc_start  input  1  request level from initiator; high = compute/hold, low = release
result  output  2*WIDTH  product, registered
done  output  1  product valid, registered
busy  output  1  high while iterating (state BUSY)

Behaviour:
- Reset (RST==0, async):
  - state=IDLE, result=0, done=0, busy=0, internal accumulator/count=0.
  - Release of reset is sampled on CLK.
- States: IDLE, BUSY, DONE.
- IDLE:
  - done=0.
  - If calc_start==1 on an edge, latch a=dataa and b=datab, clear acc (2*WIDTH bits) and count, and go to BUSY.
  - Otherwise stay.
- BUSY:
  - Each edge: if b[count]==1 then acc <= acc + (a << count), width 2*WIDTH, no overflow possible. Then count <= count+1.
  - On the edge where count==WIDTH-1: write result <= final acc (including this partial product), done <= 1, go to DONE.
  - dataa/datab changes during BUSY are ignored; operands are frozen at the latch edge.
  - If calc_start==0 is sampled in BUSY: abort to IDLE. done stays 0, result keeps its previous value.
- DONE:
  - done=1 and result held stable while calc_start==1.
  - First edge with calc_start==0: done <= 0, go to IDLE.
  - A new request needs calc_start seen low for at least that edge. The initiator also waits for done==0 before re-raising calc_start.
- Latency: calc_start first sampled high at edge k → done high after edge k+WIDTH (19 edges for WIDTH=18). done falls one edge after calc_start is sampled low.
- result changes only on completion edges; it holds the last product through IDLE and the next BUSY.
- busy = (state==BUSY), registered with the state.
- Async reset mid-BUSY or in DONE: immediate return to reset values; no partial result is written.

Test Plan:
1. Assert RST=0 asynchronously between edges → result=0, done=0, busy=0 immediately. Release and hold calc_start=0 for 5 cycles → outputs unchanged.
2. dataa=3, datab=5, raise calc_start at edge 0 → busy high for edges 1..18, done=1 after edge 18, result=15. Drop calc_start → done=0 one edge later.
3. dataa=0x08240, datab=0x07DC0 (logistic x, 1-x) → result=0x3FFAF000. Then dataa=0x3FFFF, datab=0x3FFFF → result=0xFFFF80001. Then dataa=0, datab=0x12345 → result=0.
4. Hold calc_start high 10 cycles past done while toggling dataa/datab → done stays 1 and result stable. Drop calc_start, re-raise after done==0 with new operands → new product after 19 edges.
5. dataa=7, datab=9, drop calc_start at edge 5 of BUSY → state IDLE, done never asserts, result keeps the previous product (15 from scenario 2).
6. Assert RST=0 at edge 10 of a computation → done=0, busy=0, result=0 at once. After release, a new request 2×2 → result=4 with normal latency.
